pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter XLEN, 64: width of PC and branch target.
REQ-002 Parameter REG_AW, 5: register address width.
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 reset_i  in  1  synchronous, active-low reset.
REQ-005 mem_busy_i  in  1  data memory not ready; whole pipe must hold.
REQ-006 branch_taken_i  in  1  execute-stage branch/jump resolved taken.
REQ-007 branch_target_i  in  XLEN  execute-stage redirect address.
REQ-008 dx_valid_i  in  1  execute stage holds a real instruction.
REQ-009 dx_is_load_i  in  1  execute instruction is a load.
REQ-010 dx_rd_i  in  REG_AW  execute destination register.
REQ-011 fd_rs1_i, fd_rs2_i  in  REG_AW each  decode source registers.
REQ-012 fd_rs1_use_i, fd_rs2_use_i  in  1 each  decode source actually read.
REQ-013 FD_pipeready  out  1  fetch/decode may advance this cycle.
REQ-014 fd_flush_o  out  1  invalidate fetch/decode register.
REQ-015 dx_bubble_o  out  1  load NOP into decode/execute register.
REQ-016 pc_sel_o  out  1  select pc_target_o as next PC.
REQ-017 pc_target_o  out  XLEN  redirect address.
REQ-018 stall_cnt_o, flush_cnt_o  out  32 each  performance counters.

Function
REQ-019 State register SHALL have states RUN, LU_STALL, REDIRECT, MEM_WAIT; outputs combinational from state and inputs, zero latency.
REQ-020 Load-use hazard = dx_valid_i & dx_is_load_i & dx_rd_i!=0 & ((fd_rs1_use_i & fd_rs1_i==dx_rd_i) | (fd_rs2_use_i & fd_rs2_i==dx_rd_i)).
REQ-021 RUN priority: mem_busy_i > branch_taken_i > load-use hazard > none.
REQ-022 RUN, mem_busy_i=1: FD_pipeready=0, all other outputs 0; next MEM_WAIT; if branch_taken_i also 1, latch pending redirect and branch_target_i.
REQ-023 RUN, branch_taken_i=1: pc_sel_o=1, pc_target_o=branch_target_i, fd_flush_o=1, dx_bubble_o=1, FD_pipeready=1; next REDIRECT.
REQ-024 RUN, hazard only: FD_pipeready=0, dx_bubble_o=1; next LU_STALL.
REQ-025 RUN, none: FD_pipeready=1, other outputs 0; stay RUN.
REQ-026 LU_STALL: hazard detection suppressed; branch_taken_i and mem_busy_i handled as in RUN; otherwise FD_pipeready=1, next RUN (exactly one bubble per load).
REQ-027 REDIRECT: branch_taken_i ignored (execute holds bubble); mem_busy_i handled as in RUN; otherwise FD_pipeready=1, next RUN.
REQ-028 MEM_WAIT: FD_pipeready=0 while mem_busy_i=1; branch_taken_i arriving here latched if none pending (first wins).
REQ-029 MEM_WAIT exit (mem_busy_i=0): pending redirect issued that cycle as REQ-023, pending cleared, next REDIRECT; else FD_pipeready=1, next RUN.
REQ-030 pc_target_o SHALL be 0 whenever pc_sel_o=0.

Reset
REQ-031 reset_i=0 at a clock edge: state RUN, pending redirect and stored target cleared, counters 0; overrides any operation in progress.
REQ-032 While reset_i=0, all outputs SHALL be 0, including FD_pipeready.

Configuration
REQ-033 Macro PIPE_HAZARD_PERF_CNT_EN defined: stall_cnt_o increments each cycle FD_pipeready=0 (reset excluded), flush_cnt_o each cycle fd_flush_o=1; both saturate at 0xFFFFFFFF.
REQ-034 Macro undefined: counter logic absent; stall_cnt_o and flush_cnt_o tied to 0; ports retained.

Verification
REQ-035 dx_is_load_i=1, dx_rd_i=5, fd_rs1_i=5, fd_rs1_use_i=1 -> one cycle FD_pipeready=0, dx_bubble_o=1; next cycle FD_pipeready=1 despite same inputs.
REQ-036 Same as REQ-035 but dx_rd_i=0 -> no stall, FD_pipeready=1.
REQ-037 branch_taken_i=1, branch_target_i=64'd16, simultaneous hazard -> pc_sel_o=1, pc_target_o=16, fd_flush_o=1, dx_bubble_o=1; next cycle branch_taken_i ignored.
REQ-038 mem_busy_i=1 for 3 cycles, branch_taken_i=1 target 0x40 in first -> FD_pipeready=0 for 3 cycles, then pc_sel_o=1, pc_target_o=0x40 on release cycle.
REQ-039 reset_i=0 asserted while in MEM_WAIT with pending redirect -> next cycle all outputs 0; after release no redirect issued.
REQ-040 PIPE_HAZARD_PERF_CNT_EN defined, REQ-038 sequence -> stall_cnt_o=3, flush_cnt_o=1; undefined -> both 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch redirect/flush, memory-busy hold.
// Zero-latency combinational outputs; optional perf counters under PIPE_HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              mem_busy_i,
    input  logic              branch_taken_i,
    input  logic [XLEN-1:0]   branch_target_i,
    input  logic              dx_valid_i,
    input  logic              dx_is_load_i,
    input  logic [REG_AW-1:0] dx_rd_i,
    input  logic [REG_AW-1:0] fd_rs1_i,
    input  logic [REG_AW-1:0] fd_rs2_i,
    input  logic              fd_rs1_use_i,
    input  logic              fd_rs2_use_i,
    output logic              FD_pipeready,
    output logic              fd_flush_o,
    output logic              dx_bubble_o,
    output logic              pc_sel_o,
    output logic [XLEN-1:0]   pc_target_o,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
);

    typedef enum logic [1:0] {RUN, LU_STALL, REDIRECT, MEM_WAIT} state_t;

    state_t            state_q, state_d;
    logic              pend_q, pend_d;
    logic [XLEN-1:0]   tgt_q, tgt_d;

    logic              hazard;
    logic              rdy, flush, bubble, sel;
    logic [XLEN-1:0]   target;

    always_comb begin
        hazard = dx_valid_i && dx_is_load_i && (dx_rd_i != '0) &&
                 ((fd_rs1_use_i && (fd_rs1_i == dx_rd_i)) ||
                  (fd_rs2_use_i && (fd_rs2_i == dx_rd_i)));

        state_d = state_q;
        pend_d  = pend_q;
        tgt_d   = tgt_q;
        rdy     = 1'b1;
        flush   = 1'b0;
        bubble  = 1'b0;
        sel     = 1'b0;
        target  = '0;

        case (state_q)
            RUN, LU_STALL, REDIRECT: begin
                // Execute holds a bubble in REDIRECT, so a taken branch there is stale.
                if (mem_busy_i) begin
                    rdy     = 1'b0;
                    state_d = MEM_WAIT;
                    if (branch_taken_i && (state_q != REDIRECT)) begin
                        pend_d = 1'b1;
                        tgt_d  = branch_target_i;
                    end
                end else if (branch_taken_i && (state_q != REDIRECT)) begin
                    sel     = 1'b1;
                    target  = branch_target_i;
                    flush   = 1'b1;
                    bubble  = 1'b1;
                    state_d = REDIRECT;
                end else if (hazard && (state_q == RUN)) begin
                    rdy     = 1'b0;
                    bubble  = 1'b1;
                    state_d = LU_STALL;
                end else begin
                    state_d = RUN;
                end
            end
            MEM_WAIT: begin
                if (mem_busy_i) begin
                    rdy = 1'b0;
                    if (branch_taken_i && !pend_q) begin
                        pend_d = 1'b1;
                        tgt_d  = branch_target_i;
                    end
                end else if (pend_q || branch_taken_i) begin
                    // Oldest redirect wins: the latched one if present.
                    sel     = 1'b1;
                    target  = pend_q ? tgt_q : branch_target_i;
                    flush   = 1'b1;
                    bubble  = 1'b1;
                    pend_d  = 1'b0;
                    tgt_d   = '0;
                    state_d = REDIRECT;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign FD_pipeready = reset_i && rdy;
    assign fd_flush_o   = reset_i && flush;
    assign dx_bubble_o  = reset_i && bubble;
    assign pc_sel_o     = reset_i && sel;
    assign pc_target_o  = (reset_i && sel) ? target : '0;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= RUN;
            pend_q  <= 1'b0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            tgt_q   <= tgt_d;
        end
    end

`ifdef PIPE_HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!FD_pipeready && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
        if (fd_flush_o && (flush_cnt_q != 32'hFFFF_FFFF))
            flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; expected counter values follow PIPE_HAZARD_PERF_CNT_EN.
module tb_pipe_hazard_ctrl;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        mem_busy_i;
    logic        branch_taken_i;
    logic [63:0] branch_target_i;
    logic        dx_valid_i;
    logic        dx_is_load_i;
    logic [4:0]  dx_rd_i;
    logic [4:0]  fd_rs1_i;
    logic [4:0]  fd_rs2_i;
    logic        fd_rs1_use_i;
    logic        fd_rs2_use_i;
    logic        FD_pipeready;
    logic        fd_flush_o;
    logic        dx_bubble_o;
    logic        pc_sel_o;
    logic [63:0] pc_target_o;
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;

    int n_assert = 0;
    int n_fail   = 0;

`ifdef PIPE_HAZARD_PERF_CNT_EN
    localparam logic [31:0] EXP_STALL = 32'd3;
    localparam logic [31:0] EXP_FLUSH = 32'd1;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
    localparam logic [31:0] EXP_FLUSH = 32'd0;
`endif

    pipe_hazard_ctrl #(.XLEN(64), .REG_AW(5)) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .mem_busy_i      (mem_busy_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .dx_valid_i      (dx_valid_i),
        .dx_is_load_i    (dx_is_load_i),
        .dx_rd_i         (dx_rd_i),
        .fd_rs1_i        (fd_rs1_i),
        .fd_rs2_i        (fd_rs2_i),
        .fd_rs1_use_i    (fd_rs1_use_i),
        .fd_rs2_use_i    (fd_rs2_use_i),
        .FD_pipeready    (FD_pipeready),
        .fd_flush_o      (fd_flush_o),
        .dx_bubble_o     (dx_bubble_o),
        .pc_sel_o        (pc_sel_o),
        .pc_target_o     (pc_target_o),
        .stall_cnt_o     (stall_cnt_o),
        .flush_cnt_o     (flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic rdy, input logic flush,
                           input logic bub, input logic sel, input logic [63:0] tgt);
        chk({tag, ".rdy"},   {63'd0, FD_pipeready}, {63'd0, rdy});
        chk({tag, ".flush"}, {63'd0, fd_flush_o},   {63'd0, flush});
        chk({tag, ".bub"},   {63'd0, dx_bubble_o},  {63'd0, bub});
        chk({tag, ".sel"},   {63'd0, pc_sel_o},     {63'd0, sel});
        chk({tag, ".tgt"},   pc_target_o,           tgt);
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] st, input logic [31:0] fl);
        chk({tag, ".stall_cnt"}, {32'd0, stall_cnt_o}, {32'd0, st});
        chk({tag, ".flush_cnt"}, {32'd0, flush_cnt_o}, {32'd0, fl});
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clr();
        mem_busy_i      = 1'b0;
        branch_taken_i  = 1'b0;
        branch_target_i = 64'd0;
        dx_valid_i      = 1'b0;
        dx_is_load_i    = 1'b0;
        dx_rd_i         = 5'd0;
        fd_rs1_i        = 5'd0;
        fd_rs2_i        = 5'd0;
        fd_rs1_use_i    = 1'b0;
        fd_rs2_use_i    = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic use1,
                                input logic [4:0] rs2, input logic use2);
        dx_valid_i   = 1'b1;
        dx_is_load_i = 1'b1;
        dx_rd_i      = rd;
        fd_rs1_i     = rs1;
        fd_rs1_use_i = use1;
        fd_rs2_i     = rs2;
        fd_rs2_use_i = use2;
    endtask

    initial begin
        clr();
        // Reset with busy/branch asserted: outputs must all read 0.
        reset_i = 1'b0;
        mem_busy_i = 1'b1;
        branch_taken_i = 1'b1;
        branch_target_i = 64'h1234;
        #1;
        chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
        tick();
        tick();
        chk_cnt("reset", 32'd0, 32'd0);
        clr();
        reset_i = 1'b1;
        #1;
        chk_out("idle", 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        tick();

        // Memory busy 3 cycles, branch to 0x40 in the first, later branch 0x80 must lose.
        mem_busy_i = 1'b1; branch_taken_i = 1'b1; branch_target_i = 64'h40;
        #1; chk_out("mw1", 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
        tick();
        branch_taken_i = 1'b0; branch_target_i = 64'd0;
        #1; chk_out("mw2", 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
        tick();
        branch_taken_i = 1'b1; branch_target_i = 64'h80;
        #1; chk_out("mw3", 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
        tick();
        clr();
        #1; chk_out("mw_release", 1'b1, 1'b1, 1'b1, 1'b1, 64'h40);
        tick();
        chk_cnt("mw_perf", EXP_STALL, EXP_FLUSH);
        #1; chk_out("mw_redirect", 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        tick();

        // Load-use via rs1: one bubble, then advance despite identical inputs.
        set_load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        #1; chk_out("lu_rs1", 1'b0, 1'b0, 1'b1, 1'b0, 64'd0);
        tick();
        #1; chk_out("lu_rs1_next", 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        tick();

        // Load-use via rs2, and rs2 match without use.
        clr();
        set_load_use(5'd7, 5'd3, 1'b1, 5'd7, 1'b1);
        #1; chk_out("lu_rs2", 1'b0, 1'b0, 1'b1, 1'b0, 64'd0);
        tick();
        clr();
        #1; chk_out("lu_rs2_next", 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        tick();
        set_load_use(5'd7, 5'd3, 1'b1, 5'd7, 1'b0);
        #1; chk_out("no_use", 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        tick();

        // x0 destination and non-load never stall.
        clr();
        set_load_use(5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
        #1; chk_out("rd_zero", 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        tick();
        set_load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        dx_is_load_i = 1'b0;
        #1; chk_out("not_load", 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        tick();
        dx_valid_i = 1'b0; dx_is_load_i = 1'b1;
        #1; chk_out("not_valid", 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        tick();

        // Branch beats simultaneous hazard; next cycle's branch ignored.
        clr();
        set_load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        branch_taken_i = 1'b1; branch_target_i = 64'd16;
        #1; chk_out("br_hz", 1'b1, 1'b1, 1'b1, 1'b1, 64'd16);
        tick();
        branch_target_i = 64'd99;
        #1; chk_out("br_ignored", 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        tick();
        clr();

        // Branch taken while in LU_STALL redirects.
        set_load_use(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
        tick();
        clr();
        branch_taken_i = 1'b1; branch_target_i = 64'h20;
        #1; chk_out("lu_branch", 1'b1, 1'b1, 1'b1, 1'b1, 64'h20);
        tick();
        clr();
        tick();

        // Busy while in LU_STALL holds, then plain release back to RUN.
        set_load_use(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
        tick();
        clr();
        mem_busy_i = 1'b1;
        #1; chk_out("lu_busy", 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
        tick();
        mem_busy_i = 1'b0;
        #1; chk_out("busy_release_plain", 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        tick();

        // Reset during MEM_WAIT with a pending redirect discards it.
        mem_busy_i = 1'b1; branch_taken_i = 1'b1; branch_target_i = 64'h40;
        tick();
        branch_taken_i = 1'b0;
        reset_i = 1'b0;
        #1; chk_out("rst_mw", 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
        tick();
        #1; chk_out("rst_mw_next", 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
        chk_cnt("rst_mw", 32'd0, 32'd0);
        clr();
        reset_i = 1'b1;
        #1; chk_out("rst_release", 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        tick();
        #1; chk_out("rst_release2", 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
